writeback_queue: RTL

Buffered writeback stage that sits directly upstream of the register file and drives its write port (regWrite, writeReg, writeData). Execution units hand results in over a valid/ready handshake; results are queued in a small FIFO and retired to the register file one per cycle, in order. Writes to register 0 are dropped. A two-port lookup exposes not-yet-retired results so decode can forward them instead of reading stale register-file data.

---
 rtl/writeback_queue_if.sv | 38 +++
 rtl/writeback_queue.sv | 122 ++++++++++++
 2 files changed

// File: rtl/writeback_queue_if.sv
// Bus bundle for writeback_queue: result handshake, register-file write port,
// decode forwarding lookups and occupancy.
interface writeback_queue_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_reg;
  logic [DATA_W-1:0] in_data;
  logic              wb_en;
  logic              regWrite;
  logic [ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0] writeData;
  logic [ADDR_W-1:0] lookReg1;
  logic [ADDR_W-1:0] lookReg2;
  logic              hit1;
  logic              hit2;
  logic [DATA_W-1:0] fwdData1;
  logic [DATA_W-1:0] fwdData2;
  logic [CNT_W-1:0]  count;

  // The producer/decode side drives results, drain enable and lookups.
  modport master (
    output in_valid, in_reg, in_data, wb_en, lookReg1, lookReg2,
    input  in_ready, regWrite, writeReg, writeData,
    input  hit1, hit2, fwdData1, fwdData2, count
  );

  modport slave (
    input  in_valid, in_reg, in_data, wb_en, lookReg1, lookReg2,
    output in_ready, regWrite, writeReg, writeData,
    output hit1, hit2, fwdData1, fwdData2, count
  );
endinterface

// File: rtl/writeback_queue.sv
// In-order writeback FIFO feeding the register-file write port, with
// two-port forwarding of results that have not yet reached the register file.
module writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic               clk,
  input logic               reset,
  writeback_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] entryReg  [DEPTH];
  logic [DATA_W-1:0] entryData [DEPTH];
  logic [PTR_W-1:0]  headPtr;
  logic [PTR_W-1:0]  tailPtr;
  logic [CNT_W-1:0]  countReg;
  logic              regWriteReg;
  logic [ADDR_W-1:0] writeRegReg;
  logic [DATA_W-1:0] writeDataReg;
  logic              inReady;
  logic              accept;
  logic              push;
  logic              pop;
  logic [PTR_W-1:0]  scanIdx;
  logic              hit1Int;
  logic              hit2Int;
  logic [DATA_W-1:0] fwd1Int;
  logic [DATA_W-1:0] fwd2Int;

  // Ready depends only on occupancy, so a full queue refuses even while draining.
  assign inReady = (countReg < CNT_W'(DEPTH));
  assign accept  = bus.in_valid && inReady;
  assign push    = accept && (bus.in_reg != '0);
  assign pop     = bus.wb_en && (countReg != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      entryReg[tailPtr]  <= bus.in_reg;
      entryData[tailPtr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      headPtr      <= '0;
      tailPtr      <= '0;
      countReg     <= '0;
      regWriteReg  <= 1'b0;
      writeRegReg  <= '0;
      writeDataReg <= '0;
    end else begin
      regWriteReg <= pop;
      if (push) begin
        tailPtr <= tailPtr + 1'b1;
      end
      if (pop) begin
        writeRegReg  <= entryReg[headPtr];
        writeDataReg <= entryData[headPtr];
        headPtr      <= headPtr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   countReg <= countReg + 1'b1;
        2'b01:   countReg <= countReg - 1'b1;
        default: countReg <= countReg;
      endcase
    end
  end

  // Scan oldest to youngest so a later match overrides an earlier one; the
  // output register is older than every queued entry, so it is checked first.
  always_comb begin
    hit1Int = 1'b0;
    hit2Int = 1'b0;
    fwd1Int = '0;
    fwd2Int = '0;
    scanIdx = '0;
    if (regWriteReg) begin
      if (writeRegReg == bus.lookReg1) begin
        hit1Int = 1'b1;
        fwd1Int = writeDataReg;
      end
      if (writeRegReg == bus.lookReg2) begin
        hit2Int = 1'b1;
        fwd2Int = writeDataReg;
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      scanIdx = headPtr + PTR_W'(k);
      if (CNT_W'(k) < countReg) begin
        if (entryReg[scanIdx] == bus.lookReg1) begin
          hit1Int = 1'b1;
          fwd1Int = entryData[scanIdx];
        end
        if (entryReg[scanIdx] == bus.lookReg2) begin
          hit2Int = 1'b1;
          fwd2Int = entryData[scanIdx];
        end
      end
    end
    if (bus.lookReg1 == '0) begin
      hit1Int = 1'b0;
      fwd1Int = '0;
    end
    if (bus.lookReg2 == '0) begin
      hit2Int = 1'b0;
      fwd2Int = '0;
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.count     = countReg;
  assign bus.regWrite  = regWriteReg;
  assign bus.writeReg  = writeRegReg;
  assign bus.writeData = writeDataReg;
  assign bus.hit1      = hit1Int;
  assign bus.hit2      = hit2Int;
  assign bus.fwdData1  = fwd1Int;
  assign bus.fwdData2  = fwd2Int;
endmodule
